freq_meter_multi: RTL and testbench

- Parametrised multi-channel edge/frequency counter for SNES bus and clock monitoring.
- Counts edges on NUM_CH asynchronous inputs over a fixed gate of GATE_CYCLES clk cycles and latches per-channel results.
- Adds selectable edge mode, saturation with overflow flags, enable/single-shot control and registered indexed readout.
- Sits between the SNES-side pins and the MCU-visible register file.

---
 rtl/freq_meter_multi.sv | 178 +++++++++++++++++
 tb/tb_freq_meter_multi.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_multi.sv
// Multi-channel edge counter: counts edges on NUM_CH async inputs over a fixed GATE_CYCLES gate.
// Latency: SYNC_STAGES+1 sync/history flops per input; results and done appear 1 cycle after the gate's last cycle; rd_* 1 cycle after ch_sel.
// Backpressure: none; results are overwritten at every gate boundary whether or not they have been read.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sig_in              asynchronous monitored signals, one per channel
//   en, single          measurement enable; stop after one gate (HOLD) when single=1
//   edge_mode           00/11 rising, 01 falling, 10 both; sampled at gate start only
//   ch_sel              readout channel index; out-of-range indices read as zero
//   rd_freq, rd_ovf     registered result and overflow flag of channel ch_sel
//   ovf_all             per-channel overflow flags of the last completed gate
//   done                one-cycle pulse on the first cycle new results are visible
//   meas_valid, busy    a gate has completed since reset; a gate is in progress
module freq_meter_multi #(
    parameter int NUM_CH      = 9,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 96000000,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic              en,
    input  logic              single,
    input  logic [1:0]        edge_mode,
    input  logic [SEL_W-1:0]  ch_sel,
    output logic [CNT_W-1:0]  rd_freq,
    output logic              rd_ovf,
    output logic [NUM_CH-1:0] ovf_all,
    output logic              done,
    output logic              meas_valid,
    output logic              busy
);

    localparam int GC_W = $clog2(GATE_CYCLES);
    localparam int PC_W = $clog2(SYNC_STAGES + 1);
    localparam logic [GC_W-1:0]  GATE_LAST  = GC_W'(GATE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PRIME_LAST = PC_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [SEL_W:0]   NUM_CH_L   = (SEL_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, PRIME, GATE, HOLD} state_t;

    state_t            state_q;
    logic [PC_W-1:0]   prime_cnt_q;
    logic [GC_W-1:0]   gate_cnt_q;
    logic [1:0]        mode_q;
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] hist_q;
    logic [NUM_CH-1:0] cur, rise, fall, hit;
    logic [CNT_W-1:0]  acc_q     [NUM_CH];
    logic [CNT_W-1:0]  acc_nxt   [NUM_CH];
    logic [CNT_W-1:0]  results_q [NUM_CH];
    logic [NUM_CH-1:0] sticky_q, sticky_nxt;

    // Synchroniser chain plus one history flop; edges come from the last two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cur  = sync_q[SYNC_STAGES-1];
        rise = cur & ~hist_q;
        fall = ~cur & hist_q;
        case (mode_q)
            2'b01:   hit = fall;
            2'b10:   hit = rise | fall;
            default: hit = rise;
        endcase
    end

    // Saturating increment: a full accumulator holds and raises its sticky flag.
    always_comb begin
        sticky_nxt = sticky_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_nxt[i] = acc_q[i];
            if (hit[i]) begin
                if (acc_q[i] == CNT_MAX) sticky_nxt[i] = 1'b1;
                else                     acc_nxt[i] = acc_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prime_cnt_q <= '0;
            gate_cnt_q  <= '0;
            mode_q      <= 2'b00;
            sticky_q    <= '0;
            ovf_all     <= '0;
            done        <= 1'b0;
            meas_valid  <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]     <= '0;
                results_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (!en) begin
                // Abort: the partial gate is discarded, published results stay.
                state_q     <= IDLE;
                prime_cnt_q <= '0;
                gate_cnt_q  <= '0;
                sticky_q    <= '0;
                busy        <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q     <= PRIME;
                        prime_cnt_q <= '0;
                    end
                    // Let the synchronisers fill so stale flop contents never count as edges.
                    PRIME: begin
                        if (prime_cnt_q == PRIME_LAST) begin
                            state_q    <= GATE;
                            gate_cnt_q <= '0;
                            mode_q     <= edge_mode;
                            busy       <= 1'b1;
                        end else begin
                            prime_cnt_q <= prime_cnt_q + PC_W'(1);
                        end
                    end
                    GATE: begin
                        if (gate_cnt_q == GATE_LAST) begin
                            // Boundary: this cycle's edge is included, next gate starts at once.
                            for (int i = 0; i < NUM_CH; i++) begin
                                results_q[i] <= acc_nxt[i];
                                acc_q[i]     <= '0;
                            end
                            ovf_all    <= sticky_nxt;
                            sticky_q   <= '0;
                            gate_cnt_q <= '0;
                            mode_q     <= edge_mode;
                            done       <= 1'b1;
                            meas_valid <= 1'b1;
                            if (single) begin
                                state_q <= HOLD;
                                busy    <= 1'b0;
                            end
                        end else begin
                            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_nxt[i];
                            sticky_q   <= sticky_nxt;
                            gate_cnt_q <= gate_cnt_q + GC_W'(1);
                        end
                    end
                    HOLD:    state_q <= HOLD;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_freq <= '0;
            rd_ovf  <= 1'b0;
        end else if ({1'b0, ch_sel} < NUM_CH_L) begin
            rd_freq <= results_q[ch_sel];
            rd_ovf  <= ovf_all[ch_sel];
        end else begin
            rd_freq <= '0;
            rd_ovf  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
// Bench for freq_meter_multi: one CNT_W=8 instance and one CNT_W=4 instance share all inputs.
// Latency: expected gate results are queued as stimulus is set up and compared on each done pulse.
// Backpressure: none; the scoreboard reads every channel within three cycles of done.
module tb_freq_meter_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       single = 1'b0;
    logic [1:0] edge_mode = 2'b00;
    logic [1:0] ch_sel = 2'd0;
    logic [2:0] sig_in;
    logic [7:0] rd_freq;
    logic       rd_ovf;
    logic [2:0] ovf_all;
    logic       done, meas_valid, busy;
    logic [3:0] s_rd_freq;
    logic       s_rd_ovf;
    logic [2:0] s_ovf_all;
    logic       s_done, s_meas_valid, s_busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic            chk;
        logic [2:0][15:0] e;
    } gate_t;

    gate_t sb[$];

    int per[3] = '{4, 0, 10};
    bit lvl[3] = '{1'b0, 1'b1, 1'b0};
    int t = 0;

    always #5 clk = ~clk;

    freq_meter_multi #(.NUM_CH(3), .CNT_W(8), .GATE_CYCLES(100), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .single(single),
        .edge_mode(edge_mode), .ch_sel(ch_sel), .rd_freq(rd_freq), .rd_ovf(rd_ovf),
        .ovf_all(ovf_all), .done(done), .meas_valid(meas_valid), .busy(busy)
    );

    freq_meter_multi #(.NUM_CH(3), .CNT_W(4), .GATE_CYCLES(100), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .single(single),
        .edge_mode(edge_mode), .ch_sel(ch_sel), .rd_freq(s_rd_freq), .rd_ovf(s_rd_ovf),
        .ovf_all(s_ovf_all), .done(s_done), .meas_valid(s_meas_valid), .busy(s_busy)
    );

    // Square-wave generator: per[i]=0 holds lvl[i], otherwise period per[i] clocks.
    initial begin
        sig_in = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            t++;
            for (int i = 0; i < 3; i++)
                sig_in[i] = (per[i] == 0) ? lvl[i] : ((t % per[i]) < per[i] / 2);
        end
    end

    function automatic gate_t mk(input int a, input int b, input int c, input bit k);
        gate_t g;
        g.chk  = k;
        g.e[0] = 16'(a);
        g.e[1] = 16'(b);
        g.e[2] = 16'(c);
        return g;
    endfunction

    // Scoreboard: on each done, pop the expected gate and read every channel back.
    initial begin : scoreboard
        gate_t       g;
        logic [15:0] e;
        logic [15:0] se;
        logic [2:0]  eo, seo;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: got done=1, expected no gate result");
                end else begin
                    g = sb.pop_front();
                    if (g.chk) begin
                        for (int c = 0; c < 3; c++) begin
                            eo[c]  = (g.e[c] > 16'd255);
                            seo[c] = (g.e[c] > 16'd15);
                        end
                        for (int c = 0; c < 3; c++) begin
                            ch_sel = 2'(c);
                            @(negedge clk);
                            if (c == 0) begin
                                checks++;
                                if (done !== 1'b0) begin
                                    errors++;
                                    $display("FAIL done_width: got done=%b one cycle later, expected 0", done);
                                end
                            end
                            e  = g.e[c];
                            se = (e > 16'd15) ? 16'd15 : e;
                            checks++;
                            if ({8'd0, rd_freq} !== e) begin
                                errors++;
                                $display("FAIL sb_freq ch%0d: got %0d expected %0d", c, rd_freq, e);
                            end
                            checks++;
                            if (rd_ovf !== eo[c]) begin
                                errors++;
                                $display("FAIL sb_rd_ovf ch%0d: got %b expected %b", c, rd_ovf, eo[c]);
                            end
                            checks++;
                            if ({12'd0, s_rd_freq} !== se) begin
                                errors++;
                                $display("FAIL sb_sat_freq ch%0d: got %0d expected %0d", c, s_rd_freq, se);
                            end
                            checks++;
                            if (s_rd_ovf !== seo[c]) begin
                                errors++;
                                $display("FAIL sb_sat_rd_ovf ch%0d: got %b expected %b", c, s_rd_ovf, seo[c]);
                            end
                        end
                        checks++;
                        if (ovf_all !== eo) begin
                            errors++;
                            $display("FAIL sb_ovf_all: got %b expected %b", ovf_all, eo);
                        end
                        checks++;
                        if (s_ovf_all !== seo) begin
                            errors++;
                            $display("FAIL sb_sat_ovf_all: got %b expected %b", s_ovf_all, seo);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (n < 20 && busy !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({rd_freq, rd_ovf, ovf_all, done, meas_valid, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rd_freq, rd_ovf, ovf_all, done, meas_valid, busy});
        end
        checks++;
        if ({s_rd_freq, s_rd_ovf, s_ovf_all} !== 8'd0) begin
            errors++;
            $display("FAIL reset_sat_outputs: got %h expected 0", {s_rd_freq, s_rd_ovf, s_ovf_all});
        end
        tick(3);
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_without_en: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int n;
        bit ok;
        for (int i = 0; i < 3; i++) sb.push_back(mk(25, 0, 10, 1'b1));
        en = 1'b1;
        wait_busy(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL prime_latency: busy after %0d cycles, expected 4", n);
        end
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL meas_valid_early: got %b expected 0", meas_valid);
        end
        for (int g = 0; g < 3; g++) begin
            wait_done(200, n, ok);
            checks++;
            if (!ok || n != 100) begin
                errors++;
                $display("FAIL gate_period g%0d: done after %0d cycles (seen=%b), expected 100", g, n, ok);
            end
        end
        checks++;
        if (meas_valid !== 1'b1) begin
            errors++;
            $display("FAIL meas_valid_set: got %b expected 1", meas_valid);
        end
        single = 1'b1;
        sb.push_back(mk(25, 0, 10, 1'b1));
        wait_done(200, n, ok);
        checks++;
        if (!ok || n != 100) begin
            errors++;
            $display("FAIL single_last_gate: done after %0d cycles (seen=%b), expected 100", n, ok);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b expected 0", busy);
        end
        wait_done(300, n, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL single_hold: got extra done after %0d cycles, expected none", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy: got %b expected 0", busy);
        end
        en = 1'b0;
        single = 1'b0;
        tick(2);
    endtask

    task automatic test_edge_modes();
        int n;
        bit ok;
        edge_mode = 2'b10;
        sb.push_back(mk(50, 0, 20, 1'b1));
        en = 1'b1;
        wait_done(250, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mode_both_done: got no done in %0d cycles, expected one", n);
        end
        sb.push_back(mk(50, 0, 20, 1'b1));
        tick(50);
        edge_mode = 2'b01;
        sb.push_back(mk(25, 0, 10, 1'b1));
        wait_done(200, n, ok);
        tick(50);
        edge_mode = 2'b11;
        sb.push_back(mk(25, 0, 10, 1'b1));
        wait_done(200, n, ok);
        wait_done(200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mode_seq_done: got no done in %0d cycles, expected one", n);
        end
        en = 1'b0;
        edge_mode = 2'b00;
        tick(2);
    endtask

    task automatic test_saturation();
        int n;
        bit ok;
        per[0] = 2;
        sb.push_back(mk(50, 0, 10, 1'b1));
        en = 1'b1;
        wait_done(250, n, ok);
        sb.push_back(mk(0, 0, 0, 1'b0));
        tick(50);
        per[0] = 0;
        lvl[0] = 1'b0;
        sb.push_back(mk(0, 0, 10, 1'b1));
        wait_done(200, n, ok);
        wait_done(200, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sat_idle_done: got no done in %0d cycles, expected one", n);
        end
        en = 1'b0;
        per[0] = 4;
        tick(2);
    endtask

    task automatic test_abort();
        int n;
        bit ok;
        sb.push_back(mk(25, 0, 10, 1'b1));
        en = 1'b1;
        wait_done(250, n, ok);
        tick(50);
        en = 1'b0;
        wait_done(150, n, ok);
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL abort_no_done: got done after %0d cycles, expected none", n);
        end
        checks++;
        if (meas_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got meas_valid=%b busy=%b expected 1 0", meas_valid, busy);
        end
        ch_sel = 2'd0;
        tick(2);
        checks++;
        if (rd_freq !== 8'd25) begin
            errors++;
            $display("FAIL abort_retained: got %0d expected 25", rd_freq);
        end
        checks++;
        if (s_ovf_all !== 3'b001) begin
            errors++;
            $display("FAIL abort_sat_ovf_retained: got %b expected 001", s_ovf_all);
        end
        sb.push_back(mk(25, 0, 10, 1'b1));
        en = 1'b1;
        wait_busy(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL reenable_prime: busy after %0d cycles, expected 4", n);
        end
        wait_done(200, n, ok);
        checks++;
        if (!ok || n != 100) begin
            errors++;
            $display("FAIL reenable_gate: done after %0d cycles (seen=%b), expected 100", n, ok);
        end
        en = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        en = 1'b1;
        wait_busy(n);
        tick(50);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_freq, meas_valid, busy, ovf_all, done} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset_main: got %h expected 0", {rd_freq, meas_valid, busy, ovf_all, done});
        end
        checks++;
        if ({s_rd_freq, s_ovf_all, s_meas_valid} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_sat: got %h expected 0", {s_rd_freq, s_ovf_all, s_meas_valid});
        end
        sb.push_back(mk(25, 0, 10, 1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_meas_valid: got %b expected 0", meas_valid);
        end
        wait_done(250, n, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_regate: got no done in %0d cycles, expected one", n);
        end
        en = 1'b0;
        tick(5);
    endtask

    task automatic test_readout();
        int rexp[4] = '{25, 0, 10, 0};
        int sexp[4] = '{15, 0, 10, 0};
        bit soexp[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int prev = 10;
        for (int c = 0; c < 4; c++) begin
            ch_sel = 2'(c);
            #1;
            checks++;
            if (rd_freq !== 8'(prev)) begin
                errors++;
                $display("FAIL readout_latency ch%0d: got %0d before clock, expected %0d", c, rd_freq, prev);
            end
            @(negedge clk);
            checks++;
            if (rd_freq !== 8'(rexp[c]) || rd_ovf !== 1'b0) begin
                errors++;
                $display("FAIL readout ch%0d: got %0d/%b expected %0d/0", c, rd_freq, rd_ovf, rexp[c]);
            end
            checks++;
            if (s_rd_freq !== 4'(sexp[c]) || s_rd_ovf !== soexp[c]) begin
                errors++;
                $display("FAIL readout_sat ch%0d: got %0d/%b expected %0d/%b", c, s_rd_freq, s_rd_ovf, sexp[c], soexp[c]);
            end
            prev = rexp[c];
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_modes();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_readout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending gates, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
